// File: rtl/mul_div_unit.sv
// Sequential 16x16 multiply / 16/16 divide unit writing a 32-bit result to a register pair.
// Define MDU_DIV_EN to compile in the restoring divider; otherwise op=1 returns done+dz at once.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] R,
  input  logic [15:0] S,
  input  logic [2:0]  dst,
  output logic [15:0] W,
  output logic [2:0]  W_Adr,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} state_t;

  state_t      state, state_next;
  logic [15:0] a, b;
  logic [2:0]  dst_q;
  logic [31:0] acc, acc_step;
  logic [4:0]  step;
  logic        nodiv_pulse;
  logic        accept;
  logic [16:0] mul_sum;

`ifdef MDU_DIV_EN
  logic        is_div;
  logic [16:0] rem_sh;
  logic [15:0] rem_sub;

  assign accept = start;
`else
  assign accept = start & ~op;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (step == 5'd15) state_next = WB_LO;
      WB_LO:   state_next = WB_HI;
      WB_HI:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One algorithm step; acc holds {hi, lo} in the same layout for both ops,
  // so write-back is shared: multiply {product}, divide {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[31:16]} + (b[step[3:0]] ? {1'b0, a} : 17'd0);
    acc_step = {mul_sum, acc[15:1]};
`ifdef MDU_DIV_EN
    rem_sh  = {acc[31:16], a[4'd15 - step[3:0]]};
    rem_sub = rem_sh[15:0] - b;
    if (is_div) begin
      if (rem_sh >= {1'b0, b}) acc_step = {rem_sub, acc[14:0], 1'b1};
      else                     acc_step = {rem_sh[15:0], acc[14:0], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a           <= '0;
      b           <= '0;
      dst_q       <= '0;
      acc         <= '0;
      step        <= '0;
      nodiv_pulse <= 1'b0;
`ifdef MDU_DIV_EN
      is_div      <= 1'b0;
`endif
    end else begin
`ifdef MDU_DIV_EN
      nodiv_pulse <= 1'b0;
`else
      nodiv_pulse <= (state == IDLE) && start && op;
`endif
      case (state)
        IDLE: if (accept) begin
          a     <= R;
          b     <= S;
          dst_q <= dst;
          acc   <= '0;
          step  <= '0;
`ifdef MDU_DIV_EN
          is_div <= op;
`endif
        end
        CALC: begin
          acc  <= acc_step;
          step <= step + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    W     = '0;
    W_Adr = '0;
    we    = 1'b0;
    busy  = (state != IDLE);
    done  = (state == WB_HI) || nodiv_pulse;
`ifdef MDU_DIV_EN
    dz    = (state == WB_HI) && is_div && (b == '0);
`else
    dz    = nodiv_pulse;
`endif
    case (state)
      WB_LO: begin
        we    = 1'b1;
        W_Adr = dst_q;
        W     = acc[15:0];
      end
      WB_HI: begin
        we    = 1'b1;
        W_Adr = dst_q + 3'd1;
        W     = acc[31:16];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected writes, a negedge monitor checks them.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [15:0] R, S;
  logic [2:0]  dst;
  logic [15:0] W;
  logic [2:0]  W_Adr;
  logic        we, busy, done, dz;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .R(R), .S(S), .dst(dst),
    .W(W), .W_Adr(W_Adr), .we(we), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic        w_en;
    logic [2:0]  adr;
    logic [15:0] data;
    logic        dn;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every we/done cycle must match the head of the scoreboard, otherwise outputs rest at zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (we || done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: we=%0b done=%0b W_Adr=%0d W=%h at cycle %0d, required no activity",
                   we, done, W_Adr, W, cyc);
        end else begin
          e = sb.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("we", {31'd0, we}, {31'd0, e.w_en});
          chk("W_Adr", {29'd0, W_Adr}, {29'd0, e.adr});
          chk("W", {16'd0, W}, {16'd0, e.data});
          chk("done", {31'd0, done}, {31'd0, e.dn});
          chk("dz", {31'd0, dz}, {31'd0, e.z});
        end
      end else begin
        chk("idle_outputs", {12'd0, W, W_Adr, dz}, 32'd0);
      end
    end
  end

  // Issue one operation at the current negedge; returns at the negedge where the next start is accepted.
  task automatic issue(input logic o, input logic [15:0] r, input logic [15:0] s, input logic [2:0] d);
    int unsigned t0;
    logic [31:0] p;
    logic [15:0] lo, hi;
    logic [2:0]  d1;
    logic        z;
    start = 1'b1; op = o; R = r; S = s; dst = d;
    t0 = cyc + 1;
`ifndef MDU_DIV_EN
    if (o) begin
      sb.push_back('{cyc: t0, w_en: 1'b0, adr: 3'd0, data: 16'h0, dn: 1'b1, z: 1'b1});
      @(negedge clk);
      start = 1'b0; R = 16'($urandom); S = 16'($urandom);
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      return;
    end
`endif
    z = 1'b0;
    if (o) begin
      if (s == 16'd0) begin lo = 16'hFFFF; hi = r; z = 1'b1; end
      else begin lo = r / s; hi = r % s; end
    end else begin
      p  = {16'd0, r} * {16'd0, s};
      lo = p[15:0];
      hi = p[31:16];
    end
    d1 = d + 3'd1;
    sb.push_back('{cyc: t0 + 16, w_en: 1'b1, adr: d,  data: lo, dn: 1'b0, z: 1'b0});
    sb.push_back('{cyc: t0 + 17, w_en: 1'b1, adr: d1, data: hi, dn: 1'b1, z: z});
    while (cyc < t0 + 18) begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= t0 && cyc <= t0 + 17)});
      if (cyc < t0 + 18) begin
        start = ($urandom_range(0, 3) == 0) || (cyc == t0 + 4);
        op    = 1'($urandom);
        R     = 16'($urandom);
        S     = 16'($urandom);
        dst   = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic abort_op(input logic [15:0] r, input logic [15:0] s, input int unsigned at);
    int unsigned t0;
    start = 1'b1; op = 1'b0; R = r; S = s; dst = 3'd5;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + at - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {31'd0, we}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 1'b0; R = '0; S = '0; dst = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_W", {16'd0, W}, 32'd0);
    chk("rst_W_Adr", {29'd0, W_Adr}, 32'd0);
    // reset wins over a simultaneous start
    start = 1'b1; op = 1'b0; R = 16'd9; S = 16'd9;
    @(negedge clk);
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0; start = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 16'd3, 16'd5, 3'd2);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 3'd7);
    issue(1'b1, 16'd100, 16'd7, 3'd4);
    issue(1'b1, 16'h1234, 16'd0, 3'd0);
    issue(1'b1, 16'hFFFF, 16'd1, 3'd7);
    issue(1'b0, 16'd0, 16'hABCD, 3'd3);
    for (int i = 0; i < 24; i++) begin
      issue(1'($urandom), 16'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom), 3'($urandom));
    end

    abort_op(16'h1111, 16'h2222, 10);
    issue(1'b0, 16'd12, 16'd12, 3'd6);
    repeat (30) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
